pcpu_mem_responder: RTL and testbench
=====================================

// Module: pcpu_mem_responder
// PURPOSE
//  Memory-side responder for the pcpu instruction and data buses.
//  Holds instruction memory (imem) and data memory (dmem). Answers iAddr with iData and dAddr with dData.
//  Commits dWE writes. A host-side streaming loader fills imem, then pulses cpuStart to launch the CPU.
// PARAMETERS
//  ADDR_W    8        address width of imem and dmem (depth = 2**ADDR_W)
//  DATA_W    16       word width
//  NOP_WORD  16'h0000 word driven on iData while not in RUN ({NOP,11'b0})
// PORTS
//  clock     in   1       single clock, all state on rising edge
//  reset     in   1       synchronous, active-low
//  iAddr     in   ADDR_W  CPU instruction address
//  iData     out  DATA_W  instruction word to CPU (CPU iDataIn)
//  dAddr     in   ADDR_W  CPU data address
//  dDataOut  in   DATA_W  CPU store data
//  dWE       in   1       CPU data write enable
//  dData     out  DATA_W  load data to CPU (CPU dDataIn)
//  ldData    in   DATA_W  host program word
//  ldValid   in   1       host beat valid
//  ldLast    in   1       marks final program word (qualified by ldValid)
//  ldReady   out  1       loader accepts beat
//  hostClear in   1       return from RUN to IDLE
//  cpuStart  out  1       one-cycle start pulse to CPU
//  running   out  1       state==RUN
//  overflow  out  1       program hit imem top without ldLast (sticky until reset/hostClear)
//  dWrCount  out  16      committed dmem writes (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, wptr=0, cpuStart=0, overflow=0, dWrCount=0.
//   imem/dmem contents not cleared.
//  States: IDLE -> LOAD -> START -> RUN -> IDLE.
//  IDLE: ldReady=1. An accepted beat writes imem[0], sets wptr=1, and goes to LOAD.
//   If that beat has ldLast, go to START instead.
//  LOAD: ldReady=1. Each beat (ldValid&&ldReady) writes imem[wptr]; wptr++.
//   Beat with ldLast -> START.
//   Beat accepted at wptr==2**ADDR_W-1 without ldLast: treated as last, overflow<=1, -> START. wptr never wraps.
//  START: ldReady=0; cpuStart=1 for exactly this cycle; next state RUN.
//  RUN: ldReady=0; running=1. hostClear -> IDLE with wptr=0 and overflow=0; ldValid ignored.
//  hostClear in IDLE/LOAD/START: ignored.
//  iData: combinational imem[iAddr] in RUN; NOP_WORD in all other states.
//  dData: combinational dmem[dAddr] in every state (0-latency read, as the CPU expects).
//  dmem write: rising edge, only when dWE&&running.
//   dWE outside RUN is dropped, dmem and dWrCount unchanged.
//  Read during write, same address: dData shows old word until the edge, new word after it.
//  reset low mid-LOAD: load aborted, IDLE, partial imem kept; the next load restarts at address 0.
// CONFIGURATION
//  PCPU_MEM_WCOUNT_EN defined:
//   dWrCount increments on each committed dmem write.
//   It saturates at 16'hFFFF and clears on reset or hostClear.
//  Not defined: dWrCount tied 16'h0000 and no counter logic is built.
// TESTING
//  1 Stream 3 words {ADDI,GR1,8'hAB},{LDIH,GR1,8'hCD},{HALT,11'b0}, last on beat 3
//    -> imem[0..2] match; cpuStart=1 the cycle after beat 3, running=1 the cycle after that.
//  2 RUN, dWE=1, dAddr=8'h02, dDataOut=16'hABCD for one cycle
//    -> next cycle dData@02=ABCD; dWrCount=1 (macro on) or 0 (off).
//  3 IDLE, dWE=1, dAddr=8'h05, dDataOut=16'h1234 -> dmem[05] unchanged; iData=16'h0000 for any iAddr.
//  4 256 beats, ldLast never set -> overflow=1 after beat 256, then START/RUN; ldReady=0 afterwards.
//  5 reset=0 after 2 LOAD beats, reload 1 word with last -> word written at imem[0], cpuStart pulses once.
//  6 RUN, hostClear=1 -> IDLE, overflow=0, ldReady=1, iData=16'h0000, dWrCount=0.

Source files
------------

// File: rtl/pcpu_mem_responder.sv
// -----------------------------------------------------------------------------
// pcpu_mem_responder
//
// Memory-side responder for the pcpu instruction and data buses. It holds the
// instruction memory (imem) and the data memory (dmem), answers instruction
// fetches and data loads combinationally, and commits CPU stores. A host-side
// streaming loader fills imem from address 0 upward and then launches the CPU
// with a single-cycle start pulse.
//
// Optional feature macro: PCPU_MEM_WCOUNT_EN
//   When defined, dWrCount counts committed dmem writes. The count saturates
//   at 16'hFFFF and clears on reset or on hostClear.
//   When undefined, dWrCount is tied to zero and no counter is built.
//
// Ports
//   clock     in   1       single clock, all state changes on the rising edge
//   reset     in   1       synchronous, active-low
//   iAddr     in   ADDR_W  CPU instruction address
//   iData     out  DATA_W  instruction word (imem[iAddr] in RUN, else NOP_WORD)
//   dAddr     in   ADDR_W  CPU data address
//   dDataOut  in   DATA_W  CPU store data
//   dWE       in   1       CPU data write enable (honoured only in RUN)
//   dData     out  DATA_W  load data, dmem[dAddr], zero latency
//   ldData    in   DATA_W  host program word
//   ldValid   in   1       host beat valid
//   ldLast    in   1       final program word, qualified by ldValid
//   ldReady   out  1       loader accepts a beat (IDLE and LOAD)
//   hostClear in   1       return from RUN to IDLE
//   cpuStart  out  1       one-cycle start pulse to the CPU
//   running   out  1       high while in RUN
//   overflow  out  1       program reached the top of imem without ldLast
//   dWrCount  out  16      committed dmem write count (see macro above)
// -----------------------------------------------------------------------------
module pcpu_mem_responder #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] iAddr,
    output logic [DATA_W-1:0] iData,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dDataOut,
    input  logic              dWE,
    output logic [DATA_W-1:0] dData,
    input  logic [DATA_W-1:0] ldData,
    input  logic              ldValid,
    input  logic              ldLast,
    output logic              ldReady,
    input  logic              hostClear,
    output logic              cpuStart,
    output logic              running,
    output logic              overflow,
    output logic [15:0]       dWrCount
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] WPTR_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    logic [DATA_W-1:0] imem [0:DEPTH-1];
    logic [DATA_W-1:0] dmem [0:DEPTH-1];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              overflow_q, overflow_d;
    logic              cpu_start_q, cpu_start_d;
    logic              running_q, running_d;
    logic              ld_ready_q, ld_ready_d;

    logic              ld_beat;
    logic [ADDR_W-1:0] imem_waddr;
    logic              dmem_we;

    assign ld_beat    = ldValid && ld_ready_q;
    // The first beat always lands at address 0, whatever wptr held before.
    assign imem_waddr = (state_q == ST_IDLE) ? '0 : wptr_q;
    assign dmem_we    = dWE && running_q;

    // -------------------------------------------------------------------------
    // Next-state logic for the loader / run controller
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (ld_beat) begin
                    wptr_d  = ADDR_W'(1);
                    state_d = ldLast ? ST_START : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_beat) begin
                    if (ldLast) begin
                        state_d = ST_START;
                        // Hold the pointer at the top rather than wrapping.
                        if (wptr_q != WPTR_MAX) begin
                            wptr_d = wptr_q + ADDR_W'(1);
                        end
                    end else if (wptr_q == WPTR_MAX) begin
                        // Top of imem reached without ldLast: close the load.
                        overflow_d = 1'b1;
                        state_d    = ST_START;
                    end else begin
                        wptr_d = wptr_q + ADDR_W'(1);
                    end
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (hostClear) begin
                    state_d    = ST_IDLE;
                    wptr_d     = '0;
                    overflow_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        cpu_start_d = (state_d == ST_START);
        running_d   = (state_d == ST_RUN);
        ld_ready_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            overflow_q  <= 1'b0;
            cpu_start_q <= 1'b0;
            running_q   <= 1'b0;
            ld_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            overflow_q  <= overflow_d;
            cpu_start_q <= cpu_start_d;
            running_q   <= running_d;
            ld_ready_q  <= ld_ready_d;
        end
    end

    // -------------------------------------------------------------------------
    // Memories: contents survive reset, so no reset branch here
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset && ld_beat) begin
            imem[imem_waddr] <= ldData;
        end
        if (reset && dmem_we) begin
            dmem[dAddr] <= dDataOut;
        end
    end

    // Reads are combinational; a same-address store shows up after its edge.
    assign iData = running_q ? imem[iAddr] : NOP_WORD;
    assign dData = dmem[dAddr];

    assign ldReady  = ld_ready_q;
    assign cpuStart = cpu_start_q;
    assign running  = running_q;
    assign overflow = overflow_q;

`ifdef PCPU_MEM_WCOUNT_EN
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        wr_count_d = wr_count_q;
        if (running_q && hostClear) begin
            wr_count_d = 16'h0000;
        end else if (dmem_we && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'h0001;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_count_q <= 16'h0000;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign dWrCount = wr_count_q;
`else
    assign dWrCount = 16'h0000;
`endif

endmodule

// File: tb/tb_pcpu_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_pcpu_mem_responder
//
// Directed bench for pcpu_mem_responder: program load, start pulse, RUN-time
// loads/stores, store drop outside RUN, imem overflow, reset during load and
// hostClear. Inputs change 2 time units after a rising edge; outputs are
// sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_pcpu_mem_responder;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
`ifdef PCPU_MEM_WCOUNT_EN
    localparam int WC_ON = 1;
`else
    localparam int WC_ON = 0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] iAddr;
    logic [DATA_W-1:0] iData;
    logic [ADDR_W-1:0] dAddr;
    logic [DATA_W-1:0] dDataOut;
    logic              dWE;
    logic [DATA_W-1:0] dData;
    logic [DATA_W-1:0] ldData;
    logic              ldValid;
    logic              ldLast;
    logic              ldReady;
    logic              hostClear;
    logic              cpuStart;
    logic              running;
    logic              overflow;
    logic [15:0]       dWrCount;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses;

    always #5 clock = ~clock;

    pcpu_mem_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NOP_WORD(16'h0000)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iAddr    (iAddr),
        .iData    (iData),
        .dAddr    (dAddr),
        .dDataOut (dDataOut),
        .dWE      (dWE),
        .dData    (dData),
        .ldData   (ldData),
        .ldValid  (ldValid),
        .ldLast   (ldLast),
        .ldReady  (ldReady),
        .hostClear(hostClear),
        .cpuStart (cpuStart),
        .running  (running),
        .overflow (overflow),
        .dWrCount (dWrCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; afterwards inputs may be changed safely.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic beat(input logic [DATA_W-1:0] w, input logic last);
        ldValid = 1'b1;
        ldData  = w;
        ldLast  = last;
        step();
        ldValid = 1'b0;
        ldLast  = 1'b0;
    endtask

    task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
        dWE      = 1'b1;
        dAddr    = a;
        dDataOut = w;
        step();
        dWE = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        iAddr     = '0;
        dAddr     = '0;
        dDataOut  = '0;
        dWE       = 1'b0;
        ldData    = '0;
        ldValid   = 1'b0;
        ldLast    = 1'b0;
        hostClear = 1'b0;
        step();
        step();
        settle();

        // Reset state
        check("rst_running",  32'(running),  32'd0);
        check("rst_cpuStart", 32'(cpuStart), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_wrcount",  32'(dWrCount), 32'd0);
        check("rst_ldReady",  32'(ldReady),  32'd1);
        check("rst_iData",    32'(iData),    32'h0000);

        // 1: three-word program, last on beat 3
        reset = 1'b1;
        beat(16'h49AB, 1'b0);
        settle();
        check("t1_ldReady_load", 32'(ldReady),  32'd1);
        check("t1_nostart_b1",   32'(cpuStart), 32'd0);
        beat(16'h81CD, 1'b0);
        beat(16'h0800, 1'b1);
        settle();
        check("t1_cpuStart",     32'(cpuStart), 32'd1);
        check("t1_notrun_start", 32'(running),  32'd0);
        check("t1_ldReady_start",32'(ldReady),  32'd0);
        check("t1_iData_nop",    32'(iData),    32'h0000);
        step();
        settle();
        check("t1_running",      32'(running),  32'd1);
        check("t1_cpuStart_off", 32'(cpuStart), 32'd0);
        iAddr = 8'h00; settle();
        check("t1_imem0", 32'(iData), 32'h49AB);
        iAddr = 8'h01; settle();
        check("t1_imem1", 32'(iData), 32'h81CD);
        iAddr = 8'h02; settle();
        check("t1_imem2", 32'(iData), 32'h0800);

        // 2: stores in RUN, including read-during-write at the same address
        store(8'h02, 16'h1111);
        settle();
        check("t2_first_store", 32'(dData), 32'h1111);
        dWE = 1'b1; dAddr = 8'h02; dDataOut = 16'hABCD;
        settle();
        check("t2_old_before_edge", 32'(dData), 32'h1111);
        step();
        dWE = 1'b0;
        settle();
        check("t2_new_after_edge", 32'(dData), 32'hABCD);
        check("t2_wrcount2", 32'(dWrCount), 32'(2 * WC_ON));
        store(8'h05, 16'h5555);
        settle();
        check("t2_store05",  32'(dData),    32'h5555);
        check("t2_wrcount3", 32'(dWrCount), 32'(3 * WC_ON));

        // 6 (first pass): hostClear returns to IDLE
        hostClear = 1'b1;
        step();
        hostClear = 1'b0;
        iAddr = 8'h00;
        settle();
        check("t6a_running", 32'(running),  32'd0);
        check("t6a_ldReady", 32'(ldReady),  32'd1);
        check("t6a_iData",   32'(iData),    32'h0000);
        check("t6a_wrcount", 32'(dWrCount), 32'd0);

        // 3: store in IDLE is dropped
        store(8'h05, 16'h1234);
        dAddr = 8'h05;
        settle();
        check("t3_dmem05_kept", 32'(dData),    32'h5555);
        check("t3_wrcount",     32'(dWrCount), 32'd0);
        iAddr = 8'hFF; settle();
        check("t3_iData_ff", 32'(iData), 32'h0000);
        iAddr = 8'h01; settle();
        check("t3_iData_01", 32'(iData), 32'h0000);

        // 4: 256 beats without ldLast
        for (int i = 0; i < 255; i++) begin
            beat(16'hA000 + 16'(i), 1'b0);
        end
        settle();
        check("t4_no_ovf_255",   32'(overflow), 32'd0);
        check("t4_ready_255",    32'(ldReady),  32'd1);
        beat(16'hA0FF, 1'b0);
        settle();
        check("t4_overflow",     32'(overflow), 32'd1);
        check("t4_cpuStart",     32'(cpuStart), 32'd1);
        check("t4_ldReady_off",  32'(ldReady),  32'd0);
        step();
        settle();
        check("t4_running",      32'(running),  32'd1);
        check("t4_ldReady_run",  32'(ldReady),  32'd0);
        check("t4_ovf_sticky",   32'(overflow), 32'd1);
        iAddr = 8'h00; settle();
        check("t4_imem00", 32'(iData), 32'hA000);
        iAddr = 8'hFF; settle();
        check("t4_imemff", 32'(iData), 32'hA0FF);
        // A beat offered in RUN must be ignored.
        beat(16'hDEAD, 1'b1);
        iAddr = 8'h00; settle();
        check("t4_run_ignores_ld", 32'(iData), 32'hA000);
        check("t4_still_running",  32'(running), 32'd1);

        // 6: hostClear clears the sticky overflow
        hostClear = 1'b1;
        step();
        hostClear = 1'b0;
        settle();
        check("t6_overflow", 32'(overflow), 32'd0);
        check("t6_ldReady",  32'(ldReady),  32'd1);
        check("t6_iData",    32'(iData),    32'h0000);
        check("t6_wrcount",  32'(dWrCount), 32'd0);
        check("t6_running",  32'(running),  32'd0);

        // 5: reset after two LOAD beats, then a one-word reload
        beat(16'hB001, 1'b0);
        beat(16'hB002, 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        settle();
        check("t5_ldReady_idle", 32'(ldReady),  32'd1);
        check("t5_cpuStart_low", 32'(cpuStart), 32'd0);
        beat(16'hC0DE, 1'b1);
        settle();
        check("t5_cpuStart", 32'(cpuStart), 32'd1);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            settle();
            if (cpuStart) pulses++;
        end
        check("t5_single_pulse", 32'(pulses), 32'd0);
        check("t5_running", 32'(running), 32'd1);
        iAddr = 8'h00; settle();
        check("t5_imem0", 32'(iData), 32'hC0DE);
        iAddr = 8'h01; settle();
        check("t5_imem1_kept", 32'(iData), 32'hB002);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
